// File: rtl/humidity_pkg.sv
// Shared constants and types for the humidity setpoint/converter-code paths
// (DAC output side and ADC decode side).
package humidity_pkg;

  localparam int unsigned HUM_W       = 10;
  localparam int unsigned CODE_W      = 12;
  localparam int unsigned CODE_WIDE_W = CODE_W + 1;
  localparam int unsigned FRAME_W     = 16;
  localparam int unsigned CMD_W       = 4;

  localparam int unsigned CODE_OFFSET = 2000;
  localparam int unsigned CODE_SLOPE  = 2;
  localparam int unsigned MAX_HUM     = 1000;
  localparam logic [CMD_W-1:0] CFG_BITS = 4'b0011;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    HOLD
  } state_e;

endpackage

// File: rtl/spi_tx_shift.sv
// Generic FRAME_W-bit SPI mode-0 transmitter: MSB first, sclk half-period of
// CLK_DIV clk cycles, chip select framed around exactly FRAME_W sclk pulses.
module spi_tx_shift #(
  parameter int unsigned FRAME_W = 16,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [FRAME_W-1:0] frame_i,
  output logic               last_fall_o,
  output logic               cs_n_o,
  output logic               sclk_o,
  output logic               mosi_o
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(FRAME_W);

  logic               active_q;
  logic               cs_n_q;
  logic               sclk_q;
  logic               mosi_q;
  logic [DIV_W-1:0]   div_q;
  logic [BIT_W-1:0]   bit_q;
  logic [FRAME_W-1:0] shreg_q;

  logic load;
  logic div_wrap;
  logic fall;

  assign load        = start_i && !active_q;
  assign div_wrap    = (div_q == DIV_W'(CLK_DIV - 1));
  assign fall        = active_q && div_wrap && sclk_q;
  assign last_fall_o = fall && (bit_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
    end else if (load) begin
      active_q <= 1'b1;
      cs_n_q   <= 1'b0;
      sclk_q   <= 1'b0;
      mosi_q   <= frame_i[FRAME_W-1];
      div_q    <= '0;
      bit_q    <= BIT_W'(FRAME_W - 1);
    end else if (active_q) begin
      if (div_wrap) begin
        div_q  <= '0;
        sclk_q <= ~sclk_q;
        if (sclk_q) begin
          // Falling edge: either present the next bit or close the frame.
          if (bit_q == '0) begin
            active_q <= 1'b0;
            cs_n_q   <= 1'b1;
            mosi_q   <= 1'b0;
          end else begin
            bit_q  <= bit_q - BIT_W'(1);
            mosi_q <= shreg_q[FRAME_W-2];
          end
        end
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      shreg_q <= frame_i;
    end else if (fall) begin
      shreg_q <= {shreg_q[FRAME_W-2:0], 1'b0};
    end
  end

  assign cs_n_o = cs_n_q;
  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;

endmodule

// File: rtl/humidity_to_dac.sv
// Humidity setpoint (0.1 %RH) to 12-bit DAC code, clamped at MAX_HUM and
// shipped to the external SPI DAC as {CFG_BITS, code}.
module humidity_to_dac #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned CODE_OFFSET = humidity_pkg::CODE_OFFSET,
  parameter int unsigned CODE_SLOPE  = humidity_pkg::CODE_SLOPE,
  parameter int unsigned MAX_HUM     = humidity_pkg::MAX_HUM,
  parameter logic [3:0]  CFG_BITS    = humidity_pkg::CFG_BITS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           hum_valid,
  input  logic [humidity_pkg::HUM_W-1:0] humidity,
  output logic                           hum_ready,
  output logic                           busy,
  output logic [humidity_pkg::CODE_W-1:0] code,
  output logic                           clamped,
  output logic                           dac_cs_n,
  output logic                           dac_sclk,
  output logic                           dac_mosi
);

  import humidity_pkg::*;

  localparam int unsigned HOLD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  function automatic logic [HUM_W-1:0] clamp_hum(input logic [HUM_W-1:0] h);
    return (h > HUM_W'(MAX_HUM)) ? HUM_W'(MAX_HUM) : h;
  endfunction

  // Worst case 2000 + 2*1000 = 4000 still fits the 12-bit code.
  function automatic logic [CODE_W-1:0] hum_to_code(input logic [HUM_W-1:0] h);
    return CODE_W'(CODE_WIDE_W'(CODE_OFFSET) + CODE_WIDE_W'(CODE_SLOPE) * CODE_WIDE_W'(h));
  endfunction

  state_e              state_q;
  logic                hum_ready_q;
  logic [HUM_W-1:0]    hum_q;
  logic [CODE_W-1:0]   code_q;
  logic                clamped_q;
  logic [HOLD_W-1:0]   hold_q;

  logic [CODE_W-1:0]   code_d;
  logic                clamped_d;
  logic [FRAME_W-1:0]  frame_d;
  logic                accept;
  logic                start;
  logic                last_fall;

  assign accept    = (state_q == IDLE) && hum_valid && hum_ready_q;
  assign start     = (state_q == LOAD);
  assign code_d    = hum_to_code(clamp_hum(hum_q));
  assign clamped_d = (hum_q > HUM_W'(MAX_HUM));
  assign frame_d   = {CFG_BITS, code_d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hum_ready_q <= 1'b1;
      code_q      <= '0;
      clamped_q   <= 1'b0;
      hold_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q     <= LOAD;
            hum_ready_q <= 1'b0;
          end
        end
        LOAD: begin
          code_q    <= code_d;
          clamped_q <= clamped_d;
          state_q   <= SHIFT;
        end
        SHIFT: begin
          if (last_fall) begin
            state_q <= HOLD;
            hold_q  <= '0;
          end
        end
        HOLD: begin
          // cs_n stays high here so the DAC can latch the word.
          if (hold_q == HOLD_W'(CLK_DIV - 1)) begin
            state_q     <= IDLE;
            hum_ready_q <= 1'b1;
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        default: begin
          state_q     <= IDLE;
          hum_ready_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      hum_q <= humidity;
    end
  end

  spi_tx_shift #(
    .FRAME_W (FRAME_W),
    .CLK_DIV (CLK_DIV)
  ) u_spi (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .frame_i     (frame_d),
    .last_fall_o (last_fall),
    .cs_n_o      (dac_cs_n),
    .sclk_o      (dac_sclk),
    .mosi_o      (dac_mosi)
  );

  assign hum_ready = hum_ready_q;
  assign busy      = ~hum_ready_q;
  assign code      = code_q;
  assign clamped   = clamped_q;

endmodule

// File: tb/tb_humidity_to_dac.sv
// Bench for humidity_to_dac: fixed vectors, random setpoints against an
// arithmetic reference, back-to-back, mid-frame reset and CLK_DIV=1.
module tb_humidity_to_dac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        hv4, hv1;
  logic [9:0]  hd4, hd1;
  logic        rdy4, busy4, clp4, cs4, sck4, mo4;
  logic        rdy1, busy1, clp1, cs1, sck1, mo1;
  logic [11:0] code4, code1;

  humidity_to_dac #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .hum_valid(hv4), .humidity(hd4),
    .hum_ready(rdy4), .busy(busy4), .code(code4), .clamped(clp4),
    .dac_cs_n(cs4), .dac_sclk(sck4), .dac_mosi(mo4)
  );

  humidity_to_dac #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .hum_valid(hv1), .humidity(hd1),
    .hum_ready(rdy1), .busy(busy1), .code(code1), .clamped(clp1),
    .dac_cs_n(cs1), .dac_sclk(sck1), .dac_mosi(mo1)
  );

  bit sel = 1'b0;
  logic        rdy_s, busy_s, clp_s, cs_s, sck_s, mo_s;
  logic [11:0] code_s;
  assign rdy_s  = sel ? rdy1  : rdy4;
  assign busy_s = sel ? busy1 : busy4;
  assign clp_s  = sel ? clp1  : clp4;
  assign cs_s   = sel ? cs1   : cs4;
  assign sck_s  = sel ? sck1  : sck4;
  assign mo_s   = sel ? mo1   : mo4;
  assign code_s = sel ? code1 : code4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9:0]  h;
    logic [11:0] code;
    bit          clamped;
    logic [15:0] frame;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int cdiv();
    return sel ? 1 : 4;
  endfunction

  // Reference: clamp, linear law, prepend the command nibble.
  function automatic logic [15:0] ref_frame(input int h);
    int hc;
    int c;
    logic [11:0] c12;
    hc  = (h > 1000) ? 1000 : h;
    c   = 2000 + 2 * hc;
    c12 = c[11:0];
    return {4'b0011, c12};
  endfunction

  task automatic drive(input bit v, input logic [9:0] h);
    if (sel) begin hv1 = v; hd1 = h; end
    else     begin hv4 = v; hd4 = h; end
  endtask

  task automatic do_frame(input logic [9:0] h, input bit keep, input logic [9:0] h_mid,
                          output logic [15:0] bits, output int cs_low, output int rises,
                          output int t_ready, output int rise_gap, output bit bad);
    int first_rise;
    bit prev;
    bits = '0; cs_low = 0; rises = 0; t_ready = 0; rise_gap = 0; bad = 1'b0;
    first_rise = 0; prev = 1'b0;
    for (int i = 0; i < 500 && rdy_s !== 1'b1; i++) @(negedge clk);
    drive(1'b1, h);
    @(posedge clk);
    @(negedge clk);
    if (!keep) drive(1'b0, 10'd0);
    for (int t = 1; t <= 33 * cdiv() + 20; t++) begin
      @(negedge clk);
      if (keep && t == 5) drive(1'b1, h_mid);
      if (busy_s !== ~rdy_s) bad = 1'b1;
      if (cs_s === 1'b1 && sck_s === 1'b1) bad = 1'b1;
      if (cs_s === 1'b0) cs_low++;
      if (!prev && sck_s === 1'b1 && cs_s === 1'b0) begin
        bits = {bits[14:0], mo_s};
        rises++;
        if (rises == 1) first_rise = t;
        else if (rises == 2) rise_gap = t - first_rise;
      end
      prev = (sck_s === 1'b1);
      if (rdy_s === 1'b1) begin
        t_ready = t;
        break;
      end
    end
  endtask

  task automatic run_and_verify(input string tag, input logic [9:0] h, input bit keep,
                                input logic [9:0] h_mid, input logic [15:0] exp_frame,
                                input logic [11:0] exp_code, input bit exp_clp);
    logic [15:0] bits;
    int cs_low, rises, t_ready, gap;
    bit bad;
    do_frame(h, keep, h_mid, bits, cs_low, rises, t_ready, gap, bad);
    check({tag, " frame"},   32'(bits),    32'(exp_frame));
    check({tag, " code"},    32'(code_s),  32'(exp_code));
    check({tag, " clamped"}, 32'(clp_s),   32'(exp_clp));
    check({tag, " cs_low"},  32'(cs_low),  32'(32 * cdiv()));
    check({tag, " rises"},   32'(rises),   32'd16);
    check({tag, " ready_t"}, 32'(t_ready), 32'(1 + 33 * cdiv()));
    check({tag, " sclk_gap"},32'(gap),     32'(2 * cdiv()));
    check({tag, " sclk_cs_busy"}, 32'(bad), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " ready"},   32'(rdy_s),  32'd1);
    check({tag, " busy"},    32'(busy_s), 32'd0);
    check({tag, " code"},    32'(code_s), 32'd0);
    check({tag, " clamped"}, 32'(clp_s),  32'd0);
    check({tag, " cs_n"},    32'(cs_s),   32'd1);
    check({tag, " sclk"},    32'(sck_s),  32'd0);
    check({tag, " mosi"},    32'(mo_s),   32'd0);
  endtask

  initial begin
    logic [9:0]  rh;
    logic [15:0] rf;

    vecs[0] = '{h: 10'd0,    code: 12'h7D0, clamped: 1'b0, frame: 16'h37D0};
    vecs[1] = '{h: 10'd500,  code: 12'hBB8, clamped: 1'b0, frame: 16'h3BB8};
    vecs[2] = '{h: 10'd1000, code: 12'hFA0, clamped: 1'b0, frame: 16'h3FA0};
    vecs[3] = '{h: 10'd1023, code: 12'hFA0, clamped: 1'b1, frame: 16'h3FA0};
    vecs[4] = '{h: 10'd5,    code: 12'h7DA, clamped: 1'b0, frame: 16'h37DA};

    rst_n = 1'b0;
    hv4 = 1'b0; hd4 = '0; hv1 = 1'b0; hd1 = '0;
    repeat (3) @(negedge clk);
    sel = 1'b0; #1 check_reset_state("por4");
    sel = 1'b1; #1 check_reset_state("por1");
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      run_and_verify($sformatf("vec%0d", i), vecs[i].h, 1'b0, '0,
                     vecs[i].frame, vecs[i].code, vecs[i].clamped);

    // valid held high, humidity changes mid-frame: 250 then 750
    run_and_verify("b2b_first",  10'd250, 1'b1, 10'd750, 16'h39C4, 12'h9C4, 1'b0);
    run_and_verify("b2b_second", 10'd750, 1'b0, 10'd0,   16'h3DAC, 12'hDAC, 1'b0);

    for (int i = 0; i < 12; i++) begin
      rh = 10'($urandom_range(0, 1023));
      rf = ref_frame(int'(rh));
      run_and_verify($sformatf("rand4_%0d_h%0d", i, rh), rh, 1'b0, '0,
                     rf, rf[11:0], rh > 10'd1000);
    end

    // reset asserted while bit 7 is on the wire
    for (int i = 0; i < 50 && rdy_s !== 1'b1; i++) @(negedge clk);
    drive(1'b1, 10'd300);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 10'd0);
    repeat (67) @(negedge clk);
    check("midrst precond cs_n", 32'(cs_s), 32'd0);
    rst_n = 1'b0;
    #1 check_reset_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_and_verify("after_rst", 10'd100, 1'b0, '0, 16'h3898, 12'h898, 1'b0);

    sel = 1'b1;
    run_and_verify("div1_h1", 10'd1, 1'b0, '0, 16'h37D2, 12'h7D2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      rh = 10'($urandom_range(0, 1023));
      rf = ref_frame(int'(rh));
      run_and_verify($sformatf("rand1_%0d_h%0d", i, rh), rh, 1'b0, '0,
                     rf, rf[11:0], rh > 10'd1000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
